decode_regfile: RTL
===================

Name: decode_regfile

Overview:
- Y86-64 SEQ decode stage: the read side of the register file that the writeback stage writes.
- Holds the 15 architectural registers (%rax..%r14, IDs 0-14).
- Resolves srcA/srcB from icode/rA/rB and returns registered valA/valB one cycle after a decode request.
- Accepts the dstE/valE and dstM/valM write ports driven by writeback on the same clock.

Parameters:
- WIDTH, 64, register/data width in bits.
- RSP_INIT, 0, reset value of register 4 (%rsp); all other registers reset to 0.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  decode request strobe; icode/rA/rB are sampled when high.
- icode  input  4  instruction code of the instruction being decoded.
- rA  input  4  rA field.
- rB  input  4  rB field.
- we_E  input  1  write enable, E port.
- dstE  input  4  E port destination ID; 0xF = none.
- valE  input  WIDTH  E port write data.
- we_M  input  1  write enable, M port.
- dstM  input  4  M port destination ID; 0xF = none.
- valM  input  WIDTH  M port write data.
- out_valid  output  1  valA/valB/srcA/srcB valid this cycle.
- valA  output  WIDTH  operand A.
- valB  output  WIDTH  operand B.
- srcA  output  4  resolved source A ID.
- srcB  output  4  resolved source B ID.
- dec_err  output  1  icode > 0xB seen on the accepted request.

Behaviour:
- Reset (rst_n low, asynchronous):
  - regs[0..14] = 0, except regs[4] = RSP_INIT.
  - out_valid = 0, valA = 0, valB = 0, srcA = 0xF, srcB = 0xF, dec_err = 0.
  - Holds while rst_n is low. Reset mid-request drops the request; there is no output on release.
- srcA decode, combinational on inputs:
  - icode 2, 4, 6, A -> rA.
  - icode 9, B -> 4.
  - otherwise 0xF.
- srcB decode:
  - icode 4, 5, 6 -> rB.
  - icode 8, 9, A, B -> 4.
  - otherwise 0xF.
- Read: at a rising edge with in_valid = 1, the outputs are registered:
  - valA = regs[srcA] and valB = regs[srcB]; an ID of 0xF reads as 0.
  - srcA/srcB and dec_err are latched alongside.
  - out_valid = 1 for exactly that following cycle.
- Idle: with in_valid = 0, out_valid drops to 0 next cycle. valA/valB/srcA/srcB hold their last values.
- Latency: 1 cycle. Back-to-back requests are accepted every cycle; there is no stall.
- Write, on the rising edge:
  - we_E=1 and dstE!=0xF -> regs[dstE] = valE.
  - we_M=1 and dstM!=0xF -> regs[dstM] = valM.
  - If dstE == dstM and both are enabled, valM wins (popq %rsp rule).
  - A destination ID of 0xF is ignored.
- Same-edge read/write: when a read source equals a write destination on the same edge, the read returns the new data (write-first bypass). The bypass uses the same E/M priority as the write.
- Invalid icode (0xC-0xF): srcA = srcB = 0xF, valA = valB = 0, dec_err = 1 with out_valid. The register file is unchanged.
- No arithmetic; values pass through at full WIDTH with no truncation.

Test Plan:
- Reset with RSP_INIT=0x100; request icode=9 -> out_valid=1 next cycle, srcA=srcB=4, valA=valB=0x100, all other regs read 0.
- Write E dstE=1, valE=19; next cycle request icode=6, rA=1, rB=1 -> valA=valB=19, srcA=srcB=1.
- Same edge: we_E=1, dstE=4, valE=0x20; we_M=1, dstM=4, valM=13; request icode=B -> reg 4=13 and valA=valB=13 (M priority plus bypass).
- icode=3 (irmovq) with rB=5 -> srcA=srcB=0xF, valA=valB=0; icode=D -> dec_err=1, valA=valB=0.
- dstE=0xF, valE=7 with we_E=1 -> no register changes; read all of regs 0-14 and compare with the previous values.
- Assert rst_n low during an accepted request with pending writes -> next cycle out_valid=0 and all regs are back at reset values.

Source files
------------

// File: rtl/decode_regfile_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | decode_regfile_if : decode request, writeback write and read bus   |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
interface decode_regfile_if #(
  parameter int WIDTH = 64
);
  logic             in_valid;
  logic [3:0]       icode;
  logic [3:0]       rA;
  logic [3:0]       rB;
  logic             we_E;
  logic [3:0]       dstE;
  logic [WIDTH-1:0] valE;
  logic             we_M;
  logic [3:0]       dstM;
  logic [WIDTH-1:0] valM;
  logic             out_valid;
  logic [WIDTH-1:0] valA;
  logic [WIDTH-1:0] valB;
  logic [3:0]       srcA;
  logic [3:0]       srcB;
  logic             dec_err;

  modport master (
    output in_valid, icode, rA, rB, we_E, dstE, valE, we_M, dstM, valM,
    input  out_valid, valA, valB, srcA, srcB, dec_err
  );

  modport slave (
    input  in_valid, icode, rA, rB, we_E, dstE, valE, we_M, dstM, valM,
    output out_valid, valA, valB, srcA, srcB, dec_err
  );
endinterface
`default_nettype wire

// File: rtl/decode_regfile.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | decode_regfile : Y86-64 decode stage register file, 1-cycle reads  |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
module decode_regfile #(
  parameter int               WIDTH    = 64,
  parameter logic [WIDTH-1:0] RSP_INIT = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  decode_regfile_if.slave  bus
);

  localparam logic [3:0] C_ID_NONE = 4'hF;
  localparam logic [3:0] C_ID_RSP  = 4'h4;

  logic [WIDTH-1:0] regs_q [15];
  logic [WIDTH-1:0] regs_d [15];

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] val_a_q, val_a_d;
  logic [WIDTH-1:0] val_b_q, val_b_d;
  logic [3:0]       src_a_q, src_a_d;
  logic [3:0]       src_b_q, src_b_d;
  logic             dec_err_q, dec_err_d;

  logic [3:0]       src_a_dec;
  logic [3:0]       src_b_dec;

  always_comb begin
    src_a_dec = C_ID_NONE;
    src_b_dec = C_ID_NONE;
    case (bus.icode)
      4'h2, 4'h4, 4'h6, 4'hA: src_a_dec = bus.rA;
      4'h9, 4'hB:             src_a_dec = C_ID_RSP;
      default:                src_a_dec = C_ID_NONE;
    endcase
    case (bus.icode)
      4'h4, 4'h5, 4'h6:       src_b_dec = bus.rB;
      4'h8, 4'h9, 4'hA, 4'hB: src_b_dec = C_ID_RSP;
      default:                src_b_dec = C_ID_NONE;
    endcase
  end

  // M is applied after E so it wins on a shared destination; reading from
  // regs_d gives write-first bypass with the same priority.
  always_comb begin
    regs_d = regs_q;
    if (bus.we_E && (bus.dstE != C_ID_NONE)) regs_d[bus.dstE] = bus.valE;
    if (bus.we_M && (bus.dstM != C_ID_NONE)) regs_d[bus.dstM] = bus.valM;
  end

  always_comb begin
    out_valid_d = bus.in_valid;
    val_a_d     = val_a_q;
    val_b_d     = val_b_q;
    src_a_d     = src_a_q;
    src_b_d     = src_b_q;
    dec_err_d   = dec_err_q;
    if (bus.in_valid) begin
      src_a_d   = src_a_dec;
      src_b_d   = src_b_dec;
      val_a_d   = (src_a_dec == C_ID_NONE) ? '0 : regs_d[src_a_dec];
      val_b_d   = (src_b_dec == C_ID_NONE) ? '0 : regs_d[src_b_dec];
      dec_err_d = (bus.icode > 4'hB);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 15; i++) begin
        regs_q[i] <= (i == 4) ? RSP_INIT : '0;
      end
      out_valid_q <= 1'b0;
      val_a_q     <= '0;
      val_b_q     <= '0;
      src_a_q     <= C_ID_NONE;
      src_b_q     <= C_ID_NONE;
      dec_err_q   <= 1'b0;
    end else begin
      for (int i = 0; i < 15; i++) begin
        regs_q[i] <= regs_d[i];
      end
      out_valid_q <= out_valid_d;
      val_a_q     <= val_a_d;
      val_b_q     <= val_b_d;
      src_a_q     <= src_a_d;
      src_b_q     <= src_b_d;
      dec_err_q   <= dec_err_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.valA      = val_a_q;
  assign bus.valB      = val_b_q;
  assign bus.srcA      = src_a_q;
  assign bus.srcB      = src_b_q;
  assign bus.dec_err   = dec_err_q;

endmodule
`default_nettype wire
